// File: rtl/mem_pkg.sv
// Shared types for the data-memory access sequencer: access sizes, FSM states
// and the alignment rule applied when a request is accepted.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } mau_state_t;

    // Size 2'b11 never names a legal access, so it always faults.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_WORD: bad = (addr_lo != 2'b00);
            SZ_HALF: bad = addr_lo[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane handling: merges a store lane into a captured word and
// extracts/extends a load lane from it.
module lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic        signed_i,
    output logic [31:0] store_o,
    output logic [31:0] load_o
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    assign half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];
    assign byte_s = word_i[{addr_i, 3'b000} +: 8];

    // Lane merge for stores and lane extraction with extension for loads
    always_comb begin
        store_o = word_i;
        load_o  = word_i;
        case (size_i)
            SZ_WORD: begin
                store_o = wdata_i;
                load_o  = word_i;
            end
            SZ_HALF: begin
                if (addr_i[1]) begin
                    store_o[31:16] = wdata_i[15:0];
                end else begin
                    store_o[15:0] = wdata_i[15:0];
                end
                load_o = {{16{signed_i & half_s[15]}}, half_s};
            end
            SZ_BYTE: begin
                store_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{signed_i & byte_s[7]}}, byte_s};
            end
            default: begin
                store_o = word_i;
                load_o  = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer in front of a synchronous word-addressed
// data memory; sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

    mau_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [2:0]        cnt_q;

    logic              accept_s;
    logic              read_last_s;
    logic [31:0]       store_word_s;
    logic [31:0]       load_word_s;

    assign accept_s    = req_valid && (state_q == ST_IDLE);
    assign read_last_s = (state_q == ST_READ) && (cnt_q == CNT_LAST);

    lane_merge u_lane_merge (
        .word_i   (rdata_q),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .addr_i   (addr_q[1:0]),
        .signed_i (signed_q),
        .store_o  (store_word_s),
        .load_o   (load_word_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, read-latency counter and captured memory word
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            cnt_q    <= 3'd0;
        end else begin
            if (accept_s) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                signed_q <= req_signed;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
            end
            cnt_q <= ((state_q == ST_READ) && !read_last_s) ? cnt_q + 3'd1 : 3'd0;
            if (read_last_s) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Next-state logic; only word stores skip the read phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_d = ST_IDLE;
                end else if (is_misaligned(req_size, req_addr[1:0])) begin
                    state_d = ST_ERR;
                end else if (req_write && (req_size == SZ_WORD)) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!read_last_s) begin
                    state_d = ST_READ;
                end else if (write_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0000_0000;
        misalign   = 1'b0;
        mem_addr   = '0;
        mem_wr     = 1'b0;
        mem_wdata  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_READ: mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            ST_WRITE: begin
                mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wr     = 1'b1;
                mem_wdata  = store_word_s;
                resp_valid = 1'b1;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = load_word_s;
            end
            ST_ERR:  misalign = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

endmodule
